gf2m_digit_serial_mult: RTL and testbench
=========================================

GF2M_DIGIT_SERIAL_MULT -- requirements
Module: gf2m_digit_serial_mult

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  M     233        field degree; operand and result width in bits
  D     8          digit size; bits of operand a consumed per clock
  POLY  (1<<74)|1  M-bit vector of lower terms of the irreducible f(x), with x^M implicit (default x^233+x^74+1)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk    in   1  single clock; all state changes on its rising edge
  rst_n  in   1  reset, asynchronous, active-low
  start  in   1  request; sampled only while ready=1
  a      in   M  operand A, polynomial basis, bit i = coefficient of x^i
  b      in   M  operand B, same format
  ready  out  1  high only in IDLE
  done   out  1  one-cycle pulse; c valid
  c      out  M  result A*B mod f(x)

Function
REQ-003 The block SHALL compute c = a*b mod f(x) over GF(2) using a digit-serial, MSB-first algorithm.
REQ-004 N SHALL equal ceil(M/D); a SHALL be zero-extended at the top to N*D bits.
REQ-005 The state machine SHALL have three states: IDLE, RUN, DONE.
REQ-006 IDLE with start=1 at edge k SHALL do three things:
  - latch a and b into internal registers;
  - clear the accumulator Z and the digit counter;
  - enter RUN.
REQ-007 Each RUN edge SHALL perform one step:
  - Z <= (Z*x^D mod f) + sum over j of a_digit[j]*b*x^j mod f;
  - the digit is taken from the top of the padded A;
  - the counter increments.
REQ-008 The edge that completes digit N SHALL write c <= Z_next and enter DONE, i.e. edge k+N.
REQ-009 done SHALL be 1 exactly while in DONE, for one cycle; the next edge SHALL return to IDLE.
REQ-010 Start-to-done latency SHALL be N cycles; throughput SHALL be one product per N+2 cycles.
REQ-011 start while in RUN or DONE SHALL be ignored, and a, b changes SHALL have no effect after the latch.
REQ-012 c SHALL hold its value from DONE until the next DONE; a new start SHALL NOT clear c.
REQ-013 All arithmetic SHALL be carry-free (XOR); the reduction SHALL fold the D overflow bits using POLY.
REQ-014 Results SHALL be correct for any D in 1..M, including D not dividing M.
REQ-015 A zero operand SHALL give c=0; operand 1 SHALL give c equal to the other operand.

Reset
REQ-016 rst_n=0 SHALL immediately set all of the following, independent of clk:
  - state=IDLE;
  - ready=1 (driven from state);
  - done=0;
  - c=0, Z=0, counter=0;
  - latched operands=0.
REQ-017 Reset asserted during RUN or DONE SHALL abort the operation, with no done pulse.
REQ-018 After rst_n deasserts, start SHALL be honoured at the first rising edge.

Structure
REQ-019 Package gf2m_pkg SHALL hold:
  - the state enum;
  - default M, D and POLY constants;
  - the function computing N.
REQ-020 The combinational step, Z*x^D + digit*b with reduction, SHALL be one sub-module, gf2m_digit_step, parametrised by M, D, POLY.
REQ-021 ready SHALL be decoded from state; done and c SHALL be registered.

Verification
REQ-022 Benches SHALL override parameters to M=8, D=2, POLY=8'h1B (N=4) unless a case states otherwise, and SHALL cover these cases:
  - a=0x57, b=0x83, start -> done exactly 4 cycles later, c=0xC1, ready low for 5 cycles.
  - a=0x57, b=0x13 back-to-back after ready -> c=0xFE; a start pulsed during RUN is ignored and a second done does not appear.
  - D=3 (N=3), a=0x57, b=0x83 -> c=0xC1 after 3 cycles (padding check).
  - rst_n low at cycle 2 of RUN -> done never pulses, c=0, ready=1 at once; the next start 0x02*0x80 -> c=0x1B.
  - Defaults (M=233, D=8, N=30): a=1, b=random -> c=b at cycle 30.
  - Defaults: a=x^232, b=x -> c=x^74+1.

Source files
------------

// File: rtl/gf2m_pkg.sv
// Shared types and defaults for the GF(2^m) digit-serial multiplier.
// Default field is x^233 + x^74 + 1 with 8-bit digits.
package gf2m_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned DEF_M = 233;
    localparam int unsigned DEF_D = 8;
    localparam logic [DEF_M-1:0] DEF_POLY = (DEF_M'(1) << 74) | DEF_M'(1);

    // Number of digit steps needed to consume an m-bit operand d bits at a time.
    function automatic int unsigned calc_n(input int unsigned m, input int unsigned d);
        return (m + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// One digit-serial step: z_next = (z * x^D + digit * b) mod f(x),
// with f(x) = x^M + POLY.
module gf2m_digit_step
    import gf2m_pkg::*;
#(
    parameter int unsigned     M    = DEF_M,
    parameter int unsigned     D    = DEF_D,
    parameter logic [M-1:0]    POLY = M'(DEF_POLY)
) (
    input  logic [M-1:0] z,
    input  logic [M-1:0] b,
    input  logic [D-1:0] digit,
    output logic [M-1:0] z_next
);

    // Horner form: one multiply-by-x with fold per digit bit, MSB first,
    // equals z*x^D + sum(digit[j]*b*x^j), each term reduced mod f.
    always_comb begin
        z_next = z;
        for (int unsigned i = 0; i < D; i++) begin
            z_next = (z_next << 1) ^ (z_next[M-1] ? POLY : '0);
            if (digit[D-1-i]) begin
                z_next = z_next ^ b;
            end
        end
    end

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial MSB-first GF(2^m) multiplier: c = a*b mod f(x).
// One digit of a per clock; N = ceil(M/D) cycles from start to done.
module gf2m_digit_serial_mult
    import gf2m_pkg::*;
#(
    parameter int unsigned     M    = DEF_M,
    parameter int unsigned     D    = DEF_D,
    parameter logic [M-1:0]    POLY = M'(DEF_POLY)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [M-1:0] c
);

    localparam int unsigned N  = calc_n(M, D);
    localparam int unsigned ND = N * D;
    localparam int unsigned CW = $clog2(N + 1);

    state_t          state;
    logic [ND-1:0]   a_pad;
    logic [ND-1:0]   a_sh;
    logic [M-1:0]    b_r;
    logic [M-1:0]    z;
    logic [M-1:0]    z_next;
    logic [CW-1:0]   cnt;

    // Zero-extend a at the top so the first digit lines up with the MSB end.
    always_comb begin
        a_pad        = '0;
        a_pad[M-1:0] = a;
    end

    gf2m_digit_step #(
        .M    (M),
        .D    (D),
        .POLY (POLY)
    ) u_step (
        .z      (z),
        .b      (b_r),
        .digit  (a_sh[ND-1 -: D]),
        .z_next (z_next)
    );

    assign ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_r   <= '0;
            z     <= '0;
            cnt   <= '0;
            c     <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a_pad;
                        b_r   <= b;
                        z     <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    z    <= z_next;
                    a_sh <= a_sh << D;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        c     <= z_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Scoreboard bench for gf2m_digit_serial_mult: three instances
// (M=8/D=2, M=8/D=3, defaults) checked against a long-division model.
module tb_gf2m_digit_serial_mult;

    localparam logic [232:0] TB_POLY233 = (233'(1) << 74) | 233'(1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
    logic [7:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [232:0] a2 = '0, b2 = '0;
    logic [7:0]   c0, c1;
    logic [232:0] c2;
    logic         r0, r1, r2, d0, d1, d2;

    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    typedef struct {
        logic [232:0] c;
        int unsigned  k;
        int unsigned  n;
    } exp_t;

    exp_t sq[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf2m_digit_serial_mult #(.M(8), .D(2), .POLY(8'h1B)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(s0), .a(a0), .b(b0),
        .ready(r0), .done(d0), .c(c0)
    );

    gf2m_digit_serial_mult #(.M(8), .D(3), .POLY(8'h1B)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1),
        .ready(r1), .done(d1), .c(c1)
    );

    gf2m_digit_serial_mult u_def (
        .clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2),
        .ready(r2), .done(d2), .c(c2)
    );

    // Schoolbook carry-less product followed by long division by f(x).
    function automatic logic [232:0] gf_ref(input logic [232:0] a, input logic [232:0] b,
                                            input int m, input logic [232:0] poly);
        logic [465:0] p;
        logic [465:0] f;
        p = '0;
        for (int i = 0; i < m; i++)
            if (a[i]) p = p ^ ({233'b0, b} << i);
        f = {233'b0, poly};
        f[m] = 1'b1;
        for (int k = 2 * m - 2; k >= m; k--)
            if (p[k]) p = p ^ (f << (k - m));
        return p[232:0];
    endfunction

    function automatic logic [232:0] rand233();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
        return r[232:0];
    endfunction

    function automatic logic rdy(input int i);
        case (i)
            0: return r0;
            1: return r1;
            default: return r2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [232:0] got, input logic [232:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic on_done(input int i, input logic [232:0] got);
        exp_t e;
        if (sq[i].size() == 0) begin
            chk($sformatf("unexpected_done[%0d]", i), 233'd1, 233'd0);
        end else begin
            e = sq[i].pop_front();
            chk($sformatf("c[%0d]", i), got, e.c);
            chk($sformatf("latency[%0d]", i), 233'(cyc - e.k), 233'(e.n));
        end
    endtask

    always @(negedge clk) begin
        if (d0) on_done(0, {225'b0, c0});
        if (d1) on_done(1, {225'b0, c1});
        if (d2) on_done(2, c2);
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int i, input logic [232:0] a, input logic [232:0] b);
        int unsigned n_wait;
        exp_t e;
        logic [232:0] am, bm;
        n_wait = 0;
        while (!rdy(i) && n_wait < 200) begin
            @(negedge clk);
            n_wait++;
        end
        if (!rdy(i)) begin
            chk($sformatf("ready_timeout[%0d]", i), 233'd0, 233'd1);
            return;
        end
        am = (i < 2) ? {225'b0, a[7:0]} : a;
        bm = (i < 2) ? {225'b0, b[7:0]} : b;
        case (i)
            0: begin a0 = am[7:0]; b0 = bm[7:0]; s0 = 1'b1; end
            1: begin a1 = am[7:0]; b1 = bm[7:0]; s1 = 1'b1; end
            default: begin a2 = am; b2 = bm; s2 = 1'b1; end
        endcase
        @(posedge clk);
        @(negedge clk);
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        e.c = (i < 2) ? gf_ref(am, bm, 8, 233'h1B) : gf_ref(am, bm, 233, TB_POLY233);
        e.k = cyc;
        e.n = (i == 0) ? 4 : (i == 1) ? 3 : 30;
        sq[i].push_back(e);
    endtask

    task automatic wait_idle(input int i);
        int unsigned n;
        n = 0;
        while ((sq[i].size() != 0 || !rdy(i)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sq[i].size() != 0 || !rdy(i))
            chk($sformatf("done_timeout[%0d]", i), 233'(sq[i].size()), 233'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lowc;

        repeat (3) @(negedge clk);
        chk("rst_ready0", {232'b0, r0}, 233'd1);
        chk("rst_ready1", {232'b0, r1}, 233'd1);
        chk("rst_ready2", {232'b0, r2}, 233'd1);
        chk("rst_done0",  {232'b0, d0}, 233'd0);
        chk("rst_done2",  {232'b0, d2}, 233'd0);
        chk("rst_c0", {225'b0, c0}, 233'd0);
        chk("rst_c1", {225'b0, c1}, 233'd0);
        chk("rst_c2", c2, 233'd0);
        rst_n = 1'b1;

        // 0x57*0x83 and busy window length
        issue(0, 233'h57, 233'h83);
        lowc = 0;
        while (!r0 && lowc < 50) begin
            lowc++;
            @(negedge clk);
        end
        chk("ready_low_cycles", 233'(lowc), 233'd5);
        wait_idle(0);

        // back-to-back, start during RUN ignored, operands changed after latch
        issue(0, 233'h57, 233'h13);
        a0 = 8'hFF; b0 = 8'hFF; s0 = 1'b1;
        @(negedge clk);
        s0 = 1'b0; a0 = 8'h11; b0 = 8'h22;
        wait_idle(0);
        repeat (8) @(negedge clk);
        chk("c0_hold", {225'b0, c0}, 233'hFE);

        // D=3 padding
        issue(1, 233'h57, 233'h83);
        wait_idle(1);

        // reset abort in second RUN cycle
        issue(0, 233'h57, 233'h83);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", {232'b0, r0}, 233'd1);
        chk("abort_done",  {232'b0, d0}, 233'd0);
        chk("abort_c",     {225'b0, c0}, 233'd0);
        sq[0].delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 233'h02, 233'h80);
        wait_idle(0);

        // defaults
        issue(2, 233'd1, rand233());
        wait_idle(2);
        issue(2, 233'd1 << 232, 233'd2);
        wait_idle(2);
        chk("c2_x232_times_x", c2, (233'd1 << 74) | 233'd1);

        // zero / one operands and random traffic
        issue(0, 233'd0, 233'($urandom));
        wait_idle(0);
        issue(0, 233'($urandom), 233'd1);
        wait_idle(0);
        for (int n = 0; n < 20; n++) begin
            issue(0, 233'($urandom), 233'($urandom));
            wait_idle(0);
        end
        for (int n = 0; n < 10; n++) begin
            issue(1, 233'($urandom), 233'($urandom));
            wait_idle(1);
        end
        for (int n = 0; n < 4; n++) begin
            issue(2, rand233(), rand233());
            wait_idle(2);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty0", 233'(sq[0].size()), 233'd0);
        chk("sb_empty1", 233'(sq[1].size()), 233'd0);
        chk("sb_empty2", 233'(sq[2].size()), 233'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
